// File: rtl/nonce_scheduler.sv
// Hands nonces 0..NUM_NONCES-1 to a pool of SHA-256 nonce cores and writes each
// core's final H[0] to output_addr + nonce through a single shared write port.
module nonce_scheduler #(
  parameter int NUM_NONCES = 16,
  parameter int NUM_CORES  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [15:0]               output_addr,
  output logic [NUM_CORES-1:0]      core_start,
  output logic [31:0]               core_nonce,
  input  logic [NUM_CORES-1:0]      core_done,
  input  logic [32*NUM_CORES-1:0]   core_hash,
  output logic                      mem_we,
  output logic [15:0]               mem_addr,
  output logic [31:0]               mem_write_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int              CW       = $clog2(NUM_NONCES + 1);
  localparam int              LW       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [CW-1:0]   NN       = CW'(NUM_NONCES);
  localparam logic [LW-1:0]   LAST_RST = LW'(NUM_CORES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e               state_q;
  logic [15:0]          base_q;
  logic [CW-1:0]        next_nonce_q, written_q;
  logic [NUM_CORES-1:0] cbusy_q, pend_q;
  logic [31:0]          tag_q [NUM_CORES];
  logic [31:0]          res_q [NUM_CORES];
  logic [LW-1:0]        last_q;
  logic                 err_q, busy_q, done_q, mem_we_q;
  logic [NUM_CORES-1:0] core_start_q;
  logic [31:0]          core_nonce_q, mem_data_q;
  logic [15:0]          mem_addr_q;

  logic                 start_acc, bad_done;
  logic [NUM_CORES-1:0] pend_d, disp_oh, wb_oh, cbusy_d;
  logic [31:0]          res_d [NUM_CORES];
  logic                 disp_v, wb_v;
  logic [LW-1:0]        disp_idx, wb_idx;
  logic [CW-1:0]        next_nonce_d, written_d;

  assign start_acc = start && (state_q != S_RUN);

  always_comb begin
    bad_done = 1'b0;
    pend_d   = pend_q;
    res_d    = res_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_done[i]) begin
        if (state_q == S_RUN && cbusy_q[i] && !pend_q[i]) begin
          pend_d[i] = 1'b1;
          res_d[i]  = core_hash[32*i +: 32];
        end else begin
          bad_done = 1'b1;
        end
      end
    end
  end

  // Downward scan so the lowest-index idle core is the one left selected.
  always_comb begin
    disp_v   = 1'b0;
    disp_idx = '0;
    disp_oh  = '0;
    if (state_q == S_RUN && next_nonce_q < NN) begin
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
        if (!cbusy_q[i]) begin
          disp_v     = 1'b1;
          disp_idx   = LW'(i);
          disp_oh    = '0;
          disp_oh[i] = 1'b1;
        end
      end
    end
  end

  // Results captured this cycle are already visible to the arbiter, so a
  // completion can be written on the very next cycle.
  always_comb begin : wb_sel
    int idx;
    idx    = 0;
    wb_v   = 1'b0;
    wb_idx = last_q;
    wb_oh  = '0;
    if (state_q == S_RUN) begin
      for (int k = 1; k <= NUM_CORES; k++) begin
        idx = (int'(last_q) + k) % NUM_CORES;
        if (!wb_v && pend_d[idx]) begin
          wb_v       = 1'b1;
          wb_idx     = LW'(idx);
          wb_oh[idx] = 1'b1;
        end
      end
    end
  end

  assign cbusy_d      = (cbusy_q | disp_oh) & ~wb_oh;
  assign next_nonce_d = next_nonce_q + CW'(disp_v);
  assign written_d    = written_q + CW'(wb_v);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      next_nonce_q <= '0;
      written_q    <= '0;
      cbusy_q      <= '0;
      pend_q       <= '0;
      last_q       <= LAST_RST;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      core_start_q <= '0;
      core_nonce_q <= '0;
    end else begin
      core_start_q <= '0;
      core_nonce_q <= '0;
      mem_we_q     <= 1'b0;
      err_q        <= err_q | bad_done;
      case (state_q)
        S_IDLE, S_DONE: begin
          // The accepting edge also dispatches nonce 0 to core 0.
          if (start) begin
            state_q      <= S_RUN;
            base_q       <= output_addr;
            next_nonce_q <= CW'(1);
            written_q    <= '0;
            cbusy_q      <= NUM_CORES'(1);
            pend_q       <= '0;
            last_q       <= LAST_RST;
            err_q        <= 1'b0;
            core_start_q <= NUM_CORES'(1);
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
          end
        end
        S_RUN: begin
          cbusy_q      <= cbusy_d;
          pend_q       <= pend_d & ~wb_oh;
          next_nonce_q <= next_nonce_d;
          written_q    <= written_d;
          if (disp_v) begin
            core_start_q <= disp_oh;
            core_nonce_q <= 32'(next_nonce_q);
          end
          if (wb_v) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= base_q + tag_q[wb_idx][15:0];
            mem_data_q <= res_d[wb_idx];
            last_q     <= wb_idx;
          end
          if (written_q == NN) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Per-core nonce tags and results carry no reset; cbusy/pend qualify them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      res_q[i] <= res_d[i];
    end
    if (start_acc) begin
      tag_q[0] <= '0;
    end else if (disp_v) begin
      tag_q[disp_idx] <= 32'(next_nonce_q);
    end
  end

  assign core_start     = core_start_q;
  assign core_nonce     = core_nonce_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: doc/nonce_scheduler.md
# nonce_scheduler

Dispatches the nonces of a bitcoin hash job across `NUM_CORES` parallel SHA-256 nonce cores and collects their results. Each core runs phases two and three for one nonce. The block sits between the top-level `bitcoin_hash` control and the core array. It owns the shared memory write port and writes each core's final `H[0]` to `output_addr + nonce`.

## Interface
- `NUM_NONCES`, default 16: nonces per job, must be ≥1 and ≤2^16; nonces are issued as 0..NUM_NONCES-1.
- `NUM_CORES`, default 4: number of hash cores, must be ≥1.
- `clk`  in  1  clock; the only clock, also drives `mem_clk` at top level.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  job start, sampled in IDLE or DONE only.
- `output_addr`  in  16  base address for results, latched on accepted `start`.
- `core_start`  out  NUM_CORES  one-cycle start pulse, one-hot or zero.
- `core_nonce`  out  32  nonce for the core pulsed this cycle; 0 when no pulse.
- `core_done`  in  NUM_CORES  per-core one-cycle completion pulse.
- `core_hash`  in  32*NUM_CORES  per-core final `H[0]`; core i occupies bits [32i+31:32i]; valid while `core_done[i]`=1.
- `mem_we`  out  1  write strobe.
- `mem_addr`  out  16  write address.
- `mem_write_data`  out  32  write data.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE until the next accepted `start`.
- `err`  out  1  sticky protocol error; cleared by reset or accepted `start`.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE/DONE → RUN on `start`=1. The block latches `output_addr`, clears `next_nonce`, `written`, all per-core busy/pending flags and `err`.
  - RUN → DONE in the cycle after the write that makes `written == NUM_NONCES`.
  - `start` during RUN is ignored.
- Per-core state: `cbusy[i]`, `tag[i]` (nonce), `pend[i]`, `res[i]`.
- **Dispatch** (RUN only, at most one per cycle):
  - Condition: `next_nonce < NUM_NONCES` and some core has `cbusy`=0.
  - Select the lowest-index idle core i.
  - Registered output: `core_start[i]`=1 for exactly one cycle and `core_nonce = next_nonce`.
  - Same edge: `tag[i] ← next_nonce`, `cbusy[i] ← 1`, `next_nonce++`.
- **Capture**: on `core_done[i]`=1 with `cbusy[i]`=1 and `pend[i]`=0, set `res[i] ← core_hash[i]` and `pend[i] ← 1`.
  - `core_done[i]` with `cbusy[i]`=0 or `pend[i]`=1 is ignored and sets `err`.
- **Writeback** (at most one per cycle):
  - Round-robin among cores with `pend`=1. Search starts at (last granted + 1) mod NUM_CORES; last granted resets to NUM_CORES-1.
  - Registered outputs: `mem_we`=1, `mem_addr = base + tag[g][15:0]` (mod 2^16 wrap), `mem_write_data = res[g]`.
  - Same edge: `pend[g] ← 0`, `cbusy[g] ← 0`, `written++`.
- A core freed by writeback is eligible for dispatch from the following cycle, not the same cycle.
- Dispatch, capture and writeback for different cores may all occur in the same cycle.
- Capture and writeback of the same core cannot coincide, because `pend` blocks a second capture.
- Counters `next_nonce` and `written` are sized `$clog2(NUM_NONCES+1)` bits. `tag` is 32 bits.

## Timing
- Reset values: `core_start`=0, `core_nonce`=0, `mem_we`=0, `mem_addr`=0, `mem_write_data`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- All outputs are registered.
- `start` high in cycle 0 → `busy`=1 in cycle 1; the first `core_start` (core 0, nonce 0) is in cycle 1.
  - Cores 1..NUM_CORES-1 receive nonces 1.. in cycles 2, 3, … (one per cycle).
- `core_done[i]` in cycle t → that result's `mem_we` is in cycle t+1 at the earliest, later if other results are pending.
  - Core i can be re-dispatched in cycle t+2 at the earliest.
- Final write in cycle w → `done`=1 and `busy`=0 in cycle w+1.
- `mem_we` is never high outside RUN.
- Reset asserted mid-job: every output and flag returns to its reset value at the next edge.
  - In-flight core results are discarded.
  - Cores share `reset` and must abort with it.

## Test plan
- **Basic job**, NUM_CORES=4, NUM_NONCES=16; core model returns `hash = nonce ^ 32'hA5A5_0000` 70 cycles after its start.
  - Required: 16 writes, `mem_addr` = base+0..15, correct data, every nonce dispatched exactly once, then `done`=1.
- **Simultaneous completion**: all 4 cores pulse `core_done` in the same cycle.
  - Required: 4 writes on consecutive cycles in round-robin order.
  - Required: no lost result; each freed core is redispatched 1 cycle after its write.
- **Address wrap**: `output_addr`=16'hFFFE, NUM_NONCES=4.
  - Required: writes to FFFE, FFFF, 0000, 0001.
- **Protocol error**: `core_done[2]` pulses while core 2 is idle.
  - Required: `err`=1 and stays high, no write, job completes normally; `err` clears on the next `start`.
- **Reset mid-job**: assert `reset` after 5 writes.
  - Required: all outputs 0 on the next cycle.
  - A new `start` then redispatches from nonce 0 to core 0.
- **Cores exceed nonces and restart from DONE**: NUM_CORES=4, NUM_NONCES=2.
  - Required: only cores 0 and 1 are started; `done` follows 2 writes.
  - `start` while `done`=1 begins a fresh job.
